// File: rtl/plantard_mm_sched.sv
// plantard_mm_sched: two-requester round-robin scheduler for the shared
// fixed-latency plantard_mm modular multiplier. Admits at most one operand per
// cycle, carries a (valid, owner, address) tag alongside each operand through
// a LAT-deep shift register, and returns every result to its owner. A drain
// request stops admission and returns to IDLE once the pipe is empty.
module plantard_mm_sched #(
    parameter int DW  = 12,
    parameter int AW  = 8,
    parameter int LAT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          drain,
    input  logic          req0,
    input  logic          req1,
    input  logic [DW-1:0] a0,
    input  logic [DW-1:0] a1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [DW-1:0] mm_a,
    input  logic [DW-1:0] mm_c,
    output logic          rsp_valid,
    output logic          rsp_id,
    output logic [AW-1:0] rsp_addr,
    output logic [DW-1:0] rsp_data,
    output logic          busy,
    output logic          done
);

    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic          valid;
        logic          id;
        logic [AW-1:0] addr;
    } tag_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic            prio_r;        // 0: requester 0 wins a tie, 1: requester 1 wins
    logic [CW-1:0]   inflight_r;
    tag_t            tag_r [LAT];

    logic            gnt0_s;
    logic            gnt1_s;
    logic            gnt_any_s;
    logic            done_s;
    logic            rsp_raw_s;
    logic [AW-1:0]   addr_sel_s;

    // Next-state decode and round-robin grant; reset suppresses all grants.
    always_comb begin
        state_nxt_s = state_r;
        gnt0_s      = 1'b0;
        gnt1_s      = 1'b0;
        done_s      = 1'b0;
        if (rst) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (en) state_nxt_s = RUN;
                    else    state_nxt_s = IDLE;
                end
                RUN: begin
                    // drain wins over en and blocks admission in the same cycle
                    if (drain) begin
                        state_nxt_s = DRAIN;
                    end else if (req0 && req1) begin
                        gnt0_s = (prio_r == 1'b0);
                        gnt1_s = (prio_r == 1'b1);
                    end else if (req0) begin
                        gnt0_s = 1'b1;
                    end else if (req1) begin
                        gnt1_s = 1'b1;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                DRAIN: begin
                    if (inflight_r == CW'(0)) begin
                        state_nxt_s = IDLE;
                        done_s      = 1'b1;
                    end else begin
                        state_nxt_s = DRAIN;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    assign gnt_any_s  = gnt0_s | gnt1_s;
    assign addr_sel_s = gnt1_s ? addr1 : (gnt0_s ? addr0 : {AW{1'b0}});
    assign rsp_raw_s  = tag_r[LAT-1].valid;

    // State register and round-robin pointer (moves only when something is granted).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            prio_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (gnt_any_s) prio_r <= gnt0_s;
            else           prio_r <= prio_r;
        end
    end

    // In-flight counter: +1 on admission, -1 on result, unchanged when both happen.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_r <= CW'(0);
        end else begin
            case ({gnt_any_s, rsp_raw_s})
                2'b10:   inflight_r <= inflight_r + CW'(1);
                2'b01:   inflight_r <= inflight_r - CW'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // Tag shift register tracking each operand through the multiplier latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) tag_r[i] <= '0;
        end else begin
            tag_r[0] <= '{valid: gnt_any_s, id: gnt1_s, addr: addr_sel_s};
            for (int i = 1; i < LAT; i++) tag_r[i] <= tag_r[i-1];
        end
    end

    assign gnt0      = gnt0_s;
    assign gnt1      = gnt1_s;
    assign mm_a      = gnt1_s ? a1 : (gnt0_s ? a0 : {DW{1'b0}});
    assign rsp_valid = rsp_raw_s & ~rst;
    assign rsp_id    = rsp_valid ? tag_r[LAT-1].id : 1'b0;
    assign rsp_addr  = rsp_valid ? tag_r[LAT-1].addr : {AW{1'b0}};
    assign rsp_data  = mm_c;
    assign busy      = ~rst & ((state_r != IDLE) | (inflight_r != CW'(0)));
    assign done      = done_s;

endmodule

// File: tb/tb_plantard_mm_sched.sv
// Directed testbench for plantard_mm_sched. The multiplier is stubbed as a
// 4-deep delay line so mm_c(t) = mm_a(t-4). Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge.
module tb_plantard_mm_sched;

    localparam int DW  = 12;
    localparam int AW  = 8;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst, en, drain, req0, req1;
    logic [DW-1:0] a0, a1, mm_a, mm_c, rsp_data;
    logic [AW-1:0] addr0, addr1, rsp_addr;
    logic          gnt0, gnt1, rsp_valid, rsp_id, busy, done;
    logic [DW-1:0] dl [LAT];

    int checks = 0;
    int errors = 0;

    plantard_mm_sched #(.DW(DW), .AW(AW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .en(en), .drain(drain),
        .req0(req0), .req1(req1), .a0(a0), .a1(a1),
        .addr0(addr0), .addr1(addr1), .gnt0(gnt0), .gnt1(gnt1),
        .mm_a(mm_a), .mm_c(mm_c), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_addr(rsp_addr), .rsp_data(rsp_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Multiplier stub: pure LAT-cycle delay of mm_a.
    always_ff @(posedge clk) begin
        dl[0] <= mm_a;
        for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
    end
    assign mm_c = dl[LAT-1];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        en = 1'b0; drain = 1'b0; req0 = 1'b0; req1 = 1'b0;
        a0 = '0; a1 = '0; addr0 = '0; addr1 = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1; en = 1'b1; req0 = 1'b1; req1 = 1'b1; a0 = 12'h5A5; a1 = 12'h3C3;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt c%0d got %0b%0b exp 00", c, gnt0, gnt1); end
            checks++; if (mm_a !== 12'h000) begin errors++; $display("FAIL reset_mm_a c%0d got %h exp 000", c, mm_a); end
            checks++; if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_addr !== 8'h00) begin errors++; $display("FAIL reset_rsp c%0d got v%0b id%0b addr%h exp 0/0/00", c, rsp_valid, rsp_id, rsp_addr); end
            checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done c%0d got %0b%0b exp 00", c, busy, done); end
            next_cycle();
        end
        // released, still IDLE: request must not be granted
        rst = 1'b0; en = 1'b0;
        @(negedge clk);
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_after got gnt%0b%0b busy%0b exp 0 0 0", gnt0, gnt1, busy); end
        next_cycle();
    endtask

    task automatic test_single();
        do_reset();
        en = 1'b1;                                     // c0
        @(negedge clk); next_cycle();
        en = 1'b0; req0 = 1'b1; a0 = 12'd5; addr0 = 8'h10;   // c1
        @(negedge clk);
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL single_gnt got %0b%0b exp 10", gnt0, gnt1); end
        checks++; if (mm_a !== 12'd5) begin errors++; $display("FAIL single_mm_a got %0d exp 5", mm_a); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %0b exp 1", busy); end
        next_cycle();
        req0 = 1'b0; a0 = '0; addr0 = '0;
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            if (c == 5) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_addr !== 8'h10 || rsp_data !== 12'd5) begin
                    errors++; $display("FAIL single_rsp got v%0b id%0b addr%h data%0d exp 1/0/10/5", rsp_valid, rsp_id, rsp_addr, rsp_data); end
            end else begin
                checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_norsp c%0d got %0b exp 0", c, rsp_valid); end
            end
            next_cycle();
        end
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_run got %0b exp 1", busy); end
        next_cycle();
    endtask

    task automatic test_contention();
        logic          exp_id   [1:6];
        logic [DW-1:0] exp_data [1:6];
        logic [AW-1:0] exp_addr [1:6];
        do_reset();
        en = 1'b1;
        @(negedge clk); next_cycle();
        en = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c <= 6) begin
                req0 = 1'b1; req1 = 1'b1;
                a0 = 12'h100 + 12'(c); a1 = 12'h200 + 12'(c);
                addr0 = 8'h20 + 8'(c); addr1 = 8'h40 + 8'(c);
                exp_id[c]   = (c % 2 == 0);
                exp_data[c] = exp_id[c] ? (12'h200 + 12'(c)) : (12'h100 + 12'(c));
                exp_addr[c] = exp_id[c] ? (8'h40 + 8'(c)) : (8'h20 + 8'(c));
            end else begin
                req0 = 1'b0; req1 = 1'b0;
            end
            @(negedge clk);
            if (c <= 6) begin
                checks++; if (gnt0 !== ~exp_id[c] || gnt1 !== exp_id[c]) begin errors++; $display("FAIL cont_gnt c%0d got %0b%0b exp %0b%0b", c, gnt0, gnt1, ~exp_id[c], exp_id[c]); end
                checks++; if (mm_a !== exp_data[c]) begin errors++; $display("FAIL cont_mm_a c%0d got %h exp %h", c, mm_a, exp_data[c]); end
            end
            if (c >= 5) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id[c-4] || rsp_addr !== exp_addr[c-4] || rsp_data !== exp_data[c-4]) begin
                    errors++; $display("FAIL cont_rsp c%0d got v%0b id%0b addr%h data%h exp 1/%0b/%h/%h", c, rsp_valid, rsp_id, rsp_addr, rsp_data, exp_id[c-4], exp_addr[c-4], exp_data[c-4]); end
            end else begin
                checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL cont_norsp c%0d got %0b exp 0", c, rsp_valid); end
            end
            next_cycle();
        end
    endtask

    task automatic test_rr_hold();
        do_reset();
        en = 1'b1;
        @(negedge clk); next_cycle();
        en = 1'b0;
        // c1: req1 alone, c2: nothing, c3/c4: both -> 0 then 1
        for (int c = 1; c <= 4; c++) begin
            req1 = (c != 2);
            req0 = (c >= 3);
            @(negedge clk);
            if (c == 1) begin
                checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b1) begin errors++; $display("FAIL rr_single1 got %0b%0b exp 01", gnt0, gnt1); end
            end else if (c == 2) begin
                checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++; $display("FAIL rr_none got %0b%0b exp 00", gnt0, gnt1); end
            end else begin
                checks++; if (gnt0 !== (c == 3) || gnt1 !== (c == 4)) begin errors++; $display("FAIL rr_both c%0d got %0b%0b exp %0b%0b", c, gnt0, gnt1, (c == 3), (c == 4)); end
            end
            next_cycle();
        end
    endtask

    task automatic test_drain();
        do_reset();
        en = 1'b1;
        @(negedge clk); next_cycle();
        en = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            req0 = 1'b1; a0 = 12'(c); addr0 = 8'(c);
            drain = (c == 5);
            @(negedge clk);
            if (c <= 4) begin
                checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL drain_fill c%0d got %0b exp 1", c, gnt0); end
            end else begin
                checks++; if (gnt0 !== 1'b0 || mm_a !== 12'h000) begin errors++; $display("FAIL drain_nognt c%0d got gnt%0b mm_a%h exp 0/000", c, gnt0, mm_a); end
            end
            if (c >= 5 && c <= 8) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 8'(c - 4) || rsp_data !== 12'(c - 4)) begin
                    errors++; $display("FAIL drain_rsp c%0d got v%0b addr%h data%h exp 1/%h/%h", c, rsp_valid, rsp_addr, rsp_data, 8'(c - 4), 12'(c - 4)); end
            end else if (c >= 9) begin
                checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL drain_norsp c%0d got %0b exp 0", c, rsp_valid); end
            end
            checks++; if (done !== (c == 9)) begin errors++; $display("FAIL drain_done c%0d got %0b exp %0b", c, done, (c == 9)); end
            checks++; if (busy !== (c <= 9)) begin errors++; $display("FAIL drain_busy c%0d got %0b exp %0b", c, busy, (c <= 9)); end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_idle_gating();
        do_reset();
        req0 = 1'b1; a0 = 12'd7; addr0 = 8'h77;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++; if (gnt0 !== 1'b0 || mm_a !== 12'h000 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL idle_gate c%0d got gnt%0b mm_a%h v%0b busy%0b exp 0/000/0/0", c, gnt0, mm_a, rsp_valid, busy); end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_reset_midstream();
        do_reset();
        en = 1'b1;
        @(negedge clk); next_cycle();
        en = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            req0 = 1'b1; a0 = 12'h0A0 + 12'(c); addr0 = 8'h50 + 8'(c);
            @(negedge clk);
            checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL mid_fill c%0d got %0b exp 1", c, gnt0); end
            next_cycle();
        end
        req0 = 1'b0; rst = 1'b1;
        @(negedge clk); next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                errors++; $display("FAIL mid_reset c%0d got v%0b busy%0b done%0b exp 0/0/0", c, rsp_valid, busy, done); end
            next_cycle();
        end
    endtask

    task automatic test_drain_empty();
        do_reset();
        en = 1'b1;
        @(negedge clk); next_cycle();
        en = 1'b0; drain = 1'b1; req1 = 1'b1;               // c1: RUN, empty pipe
        @(negedge clk);
        checks++; if (gnt1 !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL empty_c1 got gnt%0b done%0b exp 0/0", gnt1, done); end
        next_cycle();
        drain = 1'b0;                                        // c2: DRAIN
        @(negedge clk);
        checks++; if (done !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL empty_done got done%0b gnt%0b exp 1/0", done, gnt1); end
        next_cycle();
        en = 1'b1;                                           // c3: IDLE
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL empty_idle got done%0b busy%0b exp 0/0", done, busy); end
        next_cycle();
        en = 1'b0; a1 = 12'd9; addr1 = 8'h33;                // c4: RUN again
        @(negedge clk);
        checks++; if (gnt1 !== 1'b1 || mm_a !== 12'd9) begin errors++; $display("FAIL empty_restart got gnt%0b mm_a%0d exp 1/9", gnt1, mm_a); end
        next_cycle();
        req1 = 1'b0;
        repeat (3) begin @(negedge clk); next_cycle(); end
        @(negedge clk);                                      // c8
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_addr !== 8'h33 || rsp_data !== 12'd9) begin
            errors++; $display("FAIL empty_rsp got v%0b id%0b addr%h data%0d exp 1/1/33/9", rsp_valid, rsp_id, rsp_addr, rsp_data); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_rr_hold();
        test_drain();
        test_idle_gating();
        test_reset_midstream();
        test_drain_empty();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
